// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receiver.
//   CLKS_PER_TICK : clock cycles per oversample tick
//   OVERSAMPLE    : oversample ticks per bit period
//   DATA_BITS     : payload bits per frame (8N1)
//   SYNC_STAGES   : depth of the rx input synchronizer
//   rx_state_t    : receiver FSM states
package definitions_pkg;

    localparam int CLKS_PER_TICK = 4;
    localparam int OVERSAMPLE    = 16;
    localparam int DATA_BITS     = 8;
    localparam int SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between a line driver and the UART receiver.
//   rx        : serial line, idles high
//   dout      : last correctly framed byte
//   rx_done   : one-cycle pulse when dout updates
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : receiver is inside a frame
// master drives the line, slave is the receiver.
interface uart_rx_if;
    import definitions_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx, input dout, input rx_done, input frame_err, input busy);
    modport slave  (input rx, output dout, output rx_done, output frame_err, output busy);

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator for the UART receiver.
//   clk     : clock
//   rstN    : asynchronous active-low reset
//   restart : holds the divider at 0 (asserted while the receiver idles)
//   s_tick  : one-clock pulse every CLKS_PER_TICK clocks
module uart_rx_tick_gen #(
    parameter int CLKS_PER_TICK = definitions_pkg::CLKS_PER_TICK
) (
    input  logic clk,
    input  logic rstN,
    input  logic restart,
    output logic s_tick
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == TERM) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Holding the divider in restart keeps the first tick of a frame a full
    // tick period after the start edge is seen, so mid-bit sampling stays aligned.
    assign s_tick = !restart && (cnt_reg == TERM);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, oversampled start/data/stop detection.
//   clk  : clock, all state on the rising edge
//   rstN : asynchronous active-low reset
//   bus  : uart_rx_if.slave (rx in; dout, rx_done, frame_err, busy out)
module uart_rx #(
    parameter int CLKS_PER_TICK = definitions_pkg::CLKS_PER_TICK,
    parameter int OVERSAMPLE    = definitions_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rstN,
    uart_rx_if.slave   bus
);
    import definitions_pkg::*;

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    // Input synchronizer; stages reset to the idle (high) line level so a
    // reset release never looks like a start edge.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rstN) begin
                    if (!rstN) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= bus.rx;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rstN) begin
                    if (!rstN) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_sync = sync_reg[SYNC_STAGES-1];

    rx_state_t            state_reg;
    logic [TICK_W-1:0]    tick_cnt_reg;
    logic [2:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] dout_reg;
    logic                 rx_done_reg;
    logic                 frame_err_reg;
    logic                 busy_reg;
    logic                 s_tick;
    logic                 restart;

    // Divider sits at 0 throughout IDLE, so it starts fresh on IDLE->START.
    assign restart = (state_reg == IDLE);

    uart_rx_tick_gen #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick_gen (
        .clk     (clk),
        .rstN    (rstN),
        .restart (restart),
        .s_tick  (s_tick)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            dout_reg      <= '0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rx_sync) begin
                        state_reg    <= START;
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_cnt_reg == MID_TICK) begin
                            tick_cnt_reg <= '0;
                            if (!rx_sync) begin
                                state_reg <= DATA;
                            end else begin
                                // Low pulse shorter than half a bit: not a start bit.
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_TICK) begin
                            tick_cnt_reg <= '0;
                            // Shift in at the MSB so the first (LSB) bit ends in bit 0.
                            shift_reg    <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= STOP;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_TICK) begin
                            tick_cnt_reg <= '0;
                            state_reg    <= IDLE;
                            busy_reg     <= 1'b0;
                            if (rx_sync) begin
                                dout_reg    <= shift_reg;
                                rx_done_reg <= 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout      = dout_reg;
    assign bus.rx_done   = rx_done_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy_reg;

endmodule
